// File: rtl/spike_tally.sv
// Windowed per-neuron spike counter with a sequential argmax over the counts.
// The winning class, its count and the spike total are held on a valid/ready port.
module spike_tally #(
    parameter int unsigned p_n         = 8,
    parameter int unsigned p_cnt_width = 8,
    parameter int unsigned p_win_width = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [p_n:1]             i_spike,
    input  logic                     i_start,
    input  logic [p_win_width-1:0]   i_window,
    output logic                     o_busy,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [3:0]               o_class,
    output logic [p_cnt_width-1:0]   o_count,
    output logic [p_cnt_width+2:0]   o_total
);

    localparam int unsigned TOT_W = p_cnt_width + 3;
    localparam int unsigned IDX_W = $clog2(p_n);
    localparam logic [p_cnt_width-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_RESOLVE, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [p_cnt_width-1:0]  cnt_q [p_n];
    logic [p_cnt_width-1:0]  cnt_d [p_n];
    logic [p_win_width-1:0]  win_q, win_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              best_idx_q, best_idx_d;
    logic [p_cnt_width-1:0]  best_cnt_q, best_cnt_d;
    logic [TOT_W-1:0]        acc_q, acc_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic [3:0]              class_q, class_d;
    logic [p_cnt_width-1:0]  count_q, count_d;
    logic [TOT_W-1:0]        total_q, total_d;
    logic [p_n-1:0]          spike_v;

    assign spike_v = i_spike;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        class_d    = class_q;
        count_d    = count_q;
        total_d    = total_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_COUNT;
                    busy_d  = 1'b1;
                    for (int unsigned k = 0; k < p_n; k++) cnt_d[k] = '0;
                    // A zero-length window still counts one cycle.
                    win_d = (i_window == '0) ? p_win_width'(1) : i_window;
                end
            end
            S_COUNT: begin
                for (int unsigned k = 0; k < p_n; k++) begin
                    if (spike_v[k] && (cnt_q[k] != CNT_MAX)) begin
                        cnt_d[k] = cnt_q[k] + p_cnt_width'(1);
                    end
                end
                win_d = win_q - p_win_width'(1);
                if (win_q == p_win_width'(1)) begin
                    state_d    = S_RESOLVE;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_cnt_d = '0;
                    acc_d      = '0;
                end
            end
            S_RESOLVE: begin
                // Strictly-greater replacement keeps the lowest index on ties.
                acc_d = acc_q + TOT_W'(cnt_q[idx_q]);
                if (cnt_q[idx_q] > best_cnt_q) begin
                    best_cnt_d = cnt_q[idx_q];
                    best_idx_d = 4'(idx_q) + 4'd1;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(p_n - 1)) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                    class_d = best_idx_d;
                    count_d = best_cnt_d;
                    total_d = acc_d;
                end
            end
            S_HOLD: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            for (int unsigned k = 0; k < p_n; k++) cnt_q[k] <= '0;
            win_q      <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            count_q    <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            count_q    <= count_d;
            total_q    <= total_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_class = class_q;
    assign o_count = count_q;
    assign o_total = total_q;

endmodule

// File: tb/tb_spike_tally.sv
// Directed and randomized checks of spike_tally against a per-window counting model.
module tb_spike_tally;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:1]  spike;
    logic        start;
    logic [15:0] window;
    logic        busy, valid, ready;
    logic [3:0]  cls;
    logic [7:0]  count;
    logic [10:0] total;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:1] spk_pat [0:511];

    spike_tally dut (
        .i_clk(clk), .i_rst(rst), .i_spike(spike), .i_start(start),
        .i_window(window), .o_busy(busy), .o_valid(valid), .i_ready(ready),
        .o_class(cls), .o_count(count), .o_total(total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 512; i++) spk_pat[i] = '0;
    endtask

    // Per-neuron counts over the first n window cycles, saturated at 255; winner is the
    // lowest index holding the maximum, or 0 when nothing fired.
    function automatic void model(input int n, output int m_cls, output int m_cnt, output int m_tot);
        int c [1:8];
        int mx;
        for (int k = 1; k <= 8; k++) c[k] = 0;
        for (int i = 0; i < n; i++)
            for (int k = 1; k <= 8; k++)
                if (spk_pat[i][k]) c[k]++;
        m_tot = 0;
        mx = 0;
        for (int k = 1; k <= 8; k++) begin
            if (c[k] > 255) c[k] = 255;
            m_tot += c[k];
            if (c[k] > mx) mx = c[k];
        end
        m_cls = 0;
        m_cnt = mx;
        if (mx > 0)
            for (int k = 8; k >= 1; k--)
                if (c[k] == mx) m_cls = k;
    endfunction

    task automatic run_op(input int win, input logic [8:1] start_spk, input int hold,
                          input bit start_in_hold);
        int n, e_cls, e_cnt, e_tot;
        n = (win == 0) ? 1 : win;
        start  = 1'b1;
        window = 16'(win);
        spike  = start_spk;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            spike = spk_pat[i];
            tick();
        end
        spike = 8'hFF;
        if (hold == 0) ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("valid_low_resolve", 32'(valid), 32'd0);
            tick();
        end
        spike = '0;
        model(n, e_cls, e_cnt, e_tot);
        chk("valid_latency", 32'(valid), 32'd1);
        chk("class", 32'(cls), 32'(e_cls));
        chk("count", 32'(count), 32'(e_cnt));
        chk("total", 32'(total), 32'(e_tot));
        for (int h = 0; h < hold; h++) begin
            if (start_in_hold && h == 0) start = 1'b1;
            tick();
            start = 1'b0;
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_class", 32'(cls), 32'(e_cls));
            chk("hold_count", 32'(count), 32'(e_cnt));
            chk("hold_total", 32'(total), 32'(e_tot));
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("valid_drop", 32'(valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("idle_class_kept", 32'(cls), 32'(e_cls));
        if (start_in_hold) begin
            tick();
            chk("start_not_queued", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; spike = '0; start = 1'b0; window = '0; ready = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_class", 32'(cls), 32'd0);
        rst = 1'b0;
        tick();

        // Single winner: neuron 3 x4, neuron 6 x2, start-cycle spike ignored, start in HOLD ignored.
        clear_pat();
        spk_pat[0] = 8'h04; spk_pat[2] = 8'h20; spk_pat[3] = 8'h04;
        spk_pat[5] = 8'h04; spk_pat[7] = 8'h20; spk_pat[9] = 8'h04;
        run_op(10, 8'h20, 7, 1'b1);

        // Asynchronous abort mid-COUNT clears everything immediately.
        clear_pat();
        start = 1'b1; window = 16'd20; tick(); start = 1'b0;
        spike = 8'h01; tick(); tick(); spike = '0;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_class", 32'(cls), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_total", 32'(total), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        clear_pat();
        spk_pat[1] = 8'h80; spk_pat[3] = 8'h81;
        run_op(4, 8'h00, 1, 1'b0);

        // Tie between neurons 2 and 5; back-to-back with the previous op.
        clear_pat();
        for (int i = 0; i < 3; i++) begin
            spk_pat[2*i]   = 8'h02;
            spk_pat[2*i+1] = 8'h10;
        end
        run_op(8, 8'h00, 0, 1'b0);

        clear_pat();
        run_op(5, 8'h00, 2, 1'b0);

        // Saturation on neuron 8.
        clear_pat();
        for (int i = 0; i < 300; i++) spk_pat[i] = 8'h80;
        run_op(300, 8'h00, 0, 1'b0);

        // Zero window counts exactly one cycle.
        clear_pat();
        spk_pat[0] = 8'h44; spk_pat[1] = 8'h01; spk_pat[2] = 8'h01;
        run_op(0, 8'h01, 1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int w;
            clear_pat();
            w = int'($urandom_range(0, 40));
            for (int i = 0; i < 41; i++) begin
                case ($urandom_range(0, 3))
                    0: spk_pat[i] = 8'($urandom);
                    1: spk_pat[i] = '0;
                    default: spk_pat[i] = 8'(1 << $urandom_range(0, 7));
                endcase
            end
            run_op(w, 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spike_tally.md
# spike_tally

Windowed spike-count classifier directly downstream of the 8-neuron output layer. Over a programmable window it counts the one-cycle winner spikes the layer emits per neuron, then resolves the neuron with the highest count. The block presents the class index, its count and the total spike count on a valid/ready result port. It holds the result until the consumer accepts it.

## Interface
Parameters:
- p_n, 8, number of neurons / spike lines; fixed at 8 for this design.
- p_cnt_width, 8, width of each per-neuron saturating counter.
- p_win_width, 16, width of the window-length input.

Ports:
- i_clk  input  1  single clock; all state changes on the rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_spike  input  [p_n:1]  spike lines from the output layer; bit k set for one cycle means neuron k fired.
- i_start  input  1  single-cycle request to open a counting window.
- i_window  input  [p_win_width-1:0]  window length in cycles; sampled on accepted i_start.
- o_busy  output  1  high in every state except IDLE.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result when high together with o_valid.
- o_class  output  4  winning neuron index 1..8; 0 means no spike in the window.
- o_count  output  [p_cnt_width-1:0]  spike count of the winning neuron.
- o_total  output  [p_cnt_width+2:0]  sum of all per-neuron counts (saturated counts summed).

## Operation
- States: IDLE, COUNT, RESOLVE, HOLD. Reset puts the block in IDLE, clears all counters, and drives all outputs to 0.
- IDLE: i_start=1 → clear the p_n counters, load the window counter with max(i_window,1) (0 is treated as 1), go to COUNT. Spikes in the start cycle are not counted.
- COUNT: each cycle, every set bit k of i_spike increments counter k.
  - Counters saturate at 2^p_cnt_width−1.
  - A non-one-hot i_spike increments every set bit.
  - The window counter decrements each cycle. After the cycle in which it reaches 1, go to RESOLVE.
- RESOLVE: sequential argmax, one neuron per cycle, k=1..p_n, p_n cycles.
  - The candidate is replaced only on a strictly greater count, so ties resolve to the lowest index.
  - The total is accumulated in the same pass.
  - After neuron p_n, register o_class/o_count/o_total, assert o_valid, go to HOLD.
- A window whose counters are all zero yields o_class=0, o_count=0, o_total=0.
- HOLD: o_valid=1, and o_class/o_count/o_total stay stable.
  - On i_ready=1, drop o_valid on the next edge and go to IDLE.
  - Result outputs keep their last value in IDLE until the next result.
- i_start outside IDLE is ignored. It is not queued.
- i_spike is ignored outside COUNT.
- i_rst asserted in any state aborts the operation immediately: state goes to IDLE, all counters are cleared, all outputs go to 0. There is no partial result.

## Timing
- Accepted i_start at edge t.
- Spikes are counted at edges t+1 .. t+N, where N = max(i_window,1).
- RESOLVE occupies edges t+N+1 .. t+N+p_n.
- o_valid rises after edge t+N+p_n. Total start-to-valid latency is N+p_n cycles.
- o_busy rises after edge t and falls in the cycle after the handshake edge.
- Handshake completes on the first edge with o_valid=1 and i_ready=1.
  - i_ready held high during RESOLVE gives zero-cycle acceptance in HOLD: o_valid is high for exactly one cycle.
- Back-to-back operation: i_start may be accepted in the first IDLE cycle after the handshake.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert i_rst asynchronously mid-COUNT → o_busy, o_valid, o_class, o_count, o_total all 0 immediately. A following start with window=4 behaves normally.
- Single winner: window=10; spikes neuron 3 ×4, neuron 6 ×2 → o_valid at cycle 18 after start, o_class=3, o_count=4, o_total=6.
- Tie and empty:
  - Neurons 2 and 5 each ×3 → o_class=2, o_count=3.
  - A window of 5 with no spikes → o_class=0, o_count=0, o_total=0.
- Saturation and edges:
  - Window=300 with neuron 8 spiking every cycle → o_count=255, o_class=8.
  - A spike in the start cycle and a spike one cycle after the window are not counted.
  - i_window=0 counts exactly one cycle.
- Handshake:
  - Hold i_ready=0 for 7 cycles in HOLD → outputs stable and o_valid high throughout.
  - An i_start pulse during HOLD is ignored.
  - i_ready=1 → IDLE, and a new start is accepted the next cycle.
